// File: rtl/flush_ctrl_multi_if.sv
// Redirect request / fetch redirect bundle for flush_ctrl_multi.
// slave = controller view, master = pipeline/fetch environment view.
interface flush_ctrl_multi_if #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_SRC    = 3,
  parameter int AW         = 32
);
  localparam int SW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]    req_valid;
  logic [NUM_SRC*SW-1:0] req_stage;
  logic [NUM_SRC-1:0]    req_kill_self;
  logic [NUM_SRC*AW-1:0] req_target;
  logic                  redirect_ready;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  redirect_valid;
  logic [AW-1:0]         redirect_target;
  logic [SRCW-1:0]       redirect_src;
  logic [31:0]           flush_count;
  logic [31:0]           stall_cycles;

  modport slave (
    input  req_valid, req_stage, req_kill_self, req_target, redirect_ready,
    output flush_o, redirect_valid, redirect_target, redirect_src,
           flush_count, stall_cycles
  );

  modport master (
    output req_valid, req_stage, req_kill_self, req_target, redirect_ready,
    input  flush_o, redirect_valid, redirect_target, redirect_src,
           flush_count, stall_cycles
  );
endinterface

// File: rtl/flush_ctrl_multi.sv
// Multi-source flush/redirect controller: oldest request wins, combinational flush
// mask, registered redirect with valid/ready. Optional statistics: FLUSH_STATS_EN.
module flush_ctrl_multi #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_SRC    = 3,
  parameter int AW         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flush_ctrl_multi_if.slave    bus
);
  localparam int SW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned NS_U = NUM_STAGES;

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state;
  logic            rv_q;
  logic [AW-1:0]   tgt_q;
  logic [SRCW-1:0] src_q;

  logic            win_found;
  logic [SRCW-1:0] win_src;
  logic [SW-1:0]   win_stage;
  logic            win_kill;
  logic [AW-1:0]   win_target;
  logic [SW-1:0]   stg_c;
  logic [NUM_STAGES-1:0] flush_c;

  // Ascending scan with strict '>' keeps the lowest index on equal stage.
  always_comb begin
    win_found  = 1'b0;
    win_src    = '0;
    win_stage  = '0;
    win_kill   = 1'b0;
    win_target = '0;
    stg_c      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      stg_c = bus.req_stage[i*SW +: SW];
      if (bus.req_valid[i] && (32'(stg_c) < NS_U) &&
          (!win_found || (stg_c > win_stage))) begin
        win_found  = 1'b1;
        win_src    = SRCW'(i);
        win_stage  = stg_c;
        win_kill   = bus.req_kill_self[i];
        win_target = bus.req_target[i*AW +: AW];
      end
    end
  end

  always_comb begin
    flush_c = '0;
    if (win_found) begin
      for (int unsigned k = 0; k < NS_U; k++) begin
        if (k < 32'(win_stage))
          flush_c[k] = 1'b1;
        else if ((k == 32'(win_stage)) && win_kill)
          flush_c[k] = 1'b1;
      end
    end
    if (state == PEND)
      flush_c[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rv_q  <= 1'b0;
      tgt_q <= '0;
      src_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= PEND;
            rv_q  <= 1'b1;
            tgt_q <= win_target;
            src_q <= win_src;
          end
        end
        PEND: begin
          // A fresh winner comes from an older instruction and supersedes the pending one.
          if (win_found) begin
            tgt_q <= win_target;
            src_q <= win_src;
          end else if (bus.redirect_ready) begin
            state <= IDLE;
            rv_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_o         = flush_c;
  assign bus.redirect_valid  = rv_q;
  assign bus.redirect_target = tgt_q;
  assign bus.redirect_src    = src_q;

`ifdef FLUSH_STATS_EN
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (win_found && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if ((state == PEND) && !bus.redirect_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.flush_count  = flush_cnt_q;
  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.flush_count  = '0;
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_flush_ctrl_multi.sv
// Scoreboard bench for flush_ctrl_multi: driver pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_flush_ctrl_multi;
  localparam int NS  = 5;
  localparam int NSR = 3;
  localparam int AW  = 32;
  localparam int SW  = 3;

  typedef struct {
    logic [NS-1:0] flush;
    logic          rv;
    logic [31:0]   tgt;
    logic [1:0]    src;
    logic [31:0]   cnt;
    logic [31:0]   stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flush_ctrl_multi_if #(.NUM_STAGES(NS), .NUM_SRC(NSR), .AW(AW)) bus ();

  flush_ctrl_multi #(.NUM_STAGES(NS), .NUM_SRC(NSR), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // staged stimulus, applied just after the next rising edge
  logic [NSR-1:0] s_valid, s_kill;
  logic [SW-1:0]  s_stage[NSR];
  logic [31:0]    s_tgt[NSR];
  logic           s_ready, s_rst_n;

  // reference model state
  logic        m_pend;
  logic [31:0] m_tgt, m_cnt, m_stall;
  logic [1:0]  m_src;

  task automatic clear_reqs();
    s_valid = '0;
    s_kill  = '0;
    for (int i = 0; i < NSR; i++) begin
      s_stage[i] = '0;
      s_tgt[i]   = '0;
    end
  endtask

  task automatic set_req(input int i, input int stage, input logic kill, input logic [31:0] t);
    s_valid[i] = 1'b1;
    s_stage[i] = SW'(stage);
    s_kill[i]  = kill;
    s_tgt[i]   = t;
  endtask

  // One clock: apply staged inputs, push expected outputs, advance the model.
  task automatic cycle(input logic ovr, input logic [NS-1:0] f, input logic rv,
                       input logic [31:0] t, input logic [1:0] s);
    exp_t e;
    int   w;
    int   wst;
    @(posedge clk);
    #1;
    rst_n              = s_rst_n;
    bus.redirect_ready = s_ready;
    for (int i = 0; i < NSR; i++) begin
      bus.req_valid[i]             = s_valid[i];
      bus.req_kill_self[i]         = s_kill[i];
      bus.req_stage[i*SW +: SW]    = s_stage[i];
      bus.req_target[i*AW +: AW]   = s_tgt[i];
    end
    if (!s_rst_n) begin
      m_pend = 1'b0; m_tgt = '0; m_src = '0; m_cnt = '0; m_stall = '0;
    end
    // oldest stage first; within a stage the first source listed wins
    w = -1; wst = 0;
    for (int st = NS - 1; st >= 0 && w < 0; st--)
      for (int i = 0; i < NSR && w < 0; i++)
        if (s_valid[i] && int'(s_stage[i]) == st) begin
          w = i; wst = st;
        end
    e.flush = '0;
    if (w >= 0)
      e.flush = NS'(((1 << wst) - 1) | (int'(s_kill[w]) << wst));
    if (m_pend) e.flush[0] = 1'b1;
    e.rv  = m_pend;
    e.tgt = m_tgt;
    e.src = m_src;
`ifdef FLUSH_STATS_EN
    e.cnt   = m_cnt;
    e.stall = m_stall;
`else
    e.cnt   = '0;
    e.stall = '0;
`endif
    if (ovr) begin
      e.flush = f; e.rv = rv; e.tgt = t; e.src = s;
    end
    exp_q.push_back(e);
    if (s_rst_n) begin
      if (w >= 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_pend && !s_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (w >= 0) begin
        m_pend = 1'b1; m_tgt = s_tgt[w]; m_src = 2'(w);
      end else if (m_pend && s_ready) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flush_o",         32'(bus.flush_o),         32'(e.flush));
        chk("redirect_valid",  32'(bus.redirect_valid),  32'(e.rv));
        chk("redirect_target", bus.redirect_target,      e.tgt);
        chk("redirect_src",    32'(bus.redirect_src),    32'(e.src));
        chk("flush_count",     bus.flush_count,          e.cnt);
        chk("stall_cycles",    bus.stall_cycles,         e.stall);
      end
    end
  end

  initial begin : driver
    bus.req_valid = '0; bus.req_kill_self = '0; bus.req_stage = '0;
    bus.req_target = '0; bus.redirect_ready = 1'b0;
    m_pend = 1'b0; m_tgt = '0; m_src = '0; m_cnt = '0; m_stall = '0;
    clear_reqs();
    s_ready = 1'b1;
    s_rst_n = 1'b0;
    cycle(1'b1, 5'b00000, 1'b0, 32'h0, 2'd0);
    s_rst_n = 1'b1;
    cycle(1'b1, 5'b00000, 1'b0, 32'h0, 2'd0);

    // single branch
    set_req(1, 2, 1'b0, 32'h0040_0100);
    cycle(1'b1, 5'b00011, 1'b0, 32'h0, 2'd0);
    clear_reqs();
    cycle(1'b1, 5'b00001, 1'b1, 32'h0040_0100, 2'd1);
    cycle(1'b1, 5'b00000, 1'b0, 32'h0040_0100, 2'd1);

    // priority by age
    set_req(0, 1, 1'b0, 32'h100);
    set_req(2, 3, 1'b1, 32'h8000_0180);
    cycle(1'b1, 5'b01111, 1'b0, 32'h0040_0100, 2'd1);
    clear_reqs();
    cycle(1'b1, 5'b00001, 1'b1, 32'h8000_0180, 2'd2);
    cycle(1'b1, 5'b00000, 1'b0, 32'h8000_0180, 2'd2);

    // tie-break on equal stage
    set_req(0, 2, 1'b0, 32'hA0);
    set_req(1, 2, 1'b0, 32'hB0);
    cycle(1'b1, 5'b00011, 1'b0, 32'h8000_0180, 2'd2);
    clear_reqs();
    cycle(1'b1, 5'b00001, 1'b1, 32'hA0, 2'd0);
    cycle(1'b1, 5'b00000, 1'b0, 32'hA0, 2'd0);

    // back-pressure: three stalled cycles, then accept
    s_ready = 1'b0;
    set_req(1, 2, 1'b0, 32'h200);
    cycle(1'b1, 5'b00011, 1'b0, 32'hA0, 2'd0);
    clear_reqs();
    repeat (3) cycle(1'b1, 5'b00001, 1'b1, 32'h200, 2'd1);
    s_ready = 1'b1;
    cycle(1'b1, 5'b00001, 1'b1, 32'h200, 2'd1);
    cycle(1'b1, 5'b00000, 1'b0, 32'h200, 2'd1);

    // supersede while pending, even with ready high
    s_ready = 1'b0;
    set_req(0, 1, 1'b0, 32'h200);
    cycle(1'b1, 5'b00001, 1'b0, 32'h200, 2'd1);
    clear_reqs();
    s_ready = 1'b1;
    set_req(2, 3, 1'b0, 32'h300);
    cycle(1'b1, 5'b00111, 1'b1, 32'h200, 2'd0);
    clear_reqs();
    cycle(1'b1, 5'b00001, 1'b1, 32'h300, 2'd2);
    cycle(1'b1, 5'b00000, 1'b0, 32'h300, 2'd2);

    // reset while pending, then out-of-range stage
    s_ready = 1'b0;
    set_req(0, 1, 1'b0, 32'h400);
    cycle(1'b1, 5'b00001, 1'b0, 32'h300, 2'd2);
    clear_reqs();
    cycle(1'b1, 5'b00001, 1'b1, 32'h400, 2'd0);
    s_rst_n = 1'b0;
    cycle(1'b1, 5'b00000, 1'b0, 32'h0, 2'd0);
    s_rst_n = 1'b1;
    set_req(0, 7, 1'b1, 32'h500);
    cycle(1'b1, 5'b00000, 1'b0, 32'h0, 2'd0);
    clear_reqs();
    cycle(1'b1, 5'b00000, 1'b0, 32'h0, 2'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      clear_reqs();
      for (int i = 0; i < NSR; i++)
        if ($urandom_range(0, 3) == 0)
          set_req(i, int'($urandom_range(0, 7)), 1'(($urandom_range(0, 1))), $urandom());
      s_ready = ($urandom_range(0, 2) != 0);
      s_rst_n = ($urandom_range(0, 99) != 0);
      cycle(1'b0, '0, 1'b0, '0, '0);
    end
    s_rst_n = 1'b1;
    clear_reqs();
    cycle(1'b0, '0, 1'b0, '0, '0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flush_ctrl_multi.md
Name: flush_ctrl_multi

Overview:
Parametrised successor to the single-source branch/jump flush logic. It arbitrates redirect requests from several pipeline resolution points and selects the request from the oldest instruction. It then produces a per-stage flush mask and drives a registered redirect to fetch, using a valid/ready handshake. While fetch has not accepted the redirect, IF stays squashed, so the redirect tolerates fetch back-pressure (I-cache miss, PC mux busy).

Parameters:
NUM_STAGES, 5, number of pipeline stages; stage 0 = IF, highest index = oldest (WB)
NUM_SRC, 3, number of redirect request sources (e.g. jump in ID, branch in EX, exception in MEM)
AW, 32, redirect target address width
SW, $clog2(NUM_STAGES), stage index width (derived; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_SRC  per-source redirect request
req_stage  in  NUM_SRC*SW  per-source stage index where the redirect resolved; source i at [i*SW +: SW]
req_kill_self  in  NUM_SRC  1 = also flush the resolving stage (exception); 0 = keep it (branch/jump)
req_target  in  NUM_SRC*AW  per-source target PC; source i at [i*AW +: AW]
redirect_ready  in  1  fetch accepts the redirect this cycle
flush_o  out  NUM_STAGES  per-stage flush, bit k = stage k
redirect_valid  out  1  registered redirect request to fetch
redirect_target  out  AW  registered redirect PC
redirect_src  out  $clog2(NUM_SRC) (min 1)  index of the source that produced the current redirect
flush_count  out  32  statistics, see Optional Feature
stall_cycles  out  32  statistics, see Optional Feature

Behaviour:
- Reset (async, rst_n=0): state IDLE; redirect_valid=0; redirect_target=0; redirect_src=0; counters=0. Reset mid-PEND drops the pending redirect. flush_o is then driven from the current inputs only, with the PEND term at 0.
- Request qualification: a source is eligible iff req_valid[i]=1 and req_stage[i] < NUM_STAGES. Out-of-range stage indices are ignored silently.
- Arbitration (combinational): the winner is the eligible source with the largest req_stage. On equal stage, the lowest source index wins.
- flush_o is combinational, in the same cycle as the winning request:
  - bit k=1 for all k < winner stage;
  - bit k=1 for k = winner stage when req_kill_self[winner]=1;
  - OR bit 0 = 1 whenever state = PEND.
  - No winner and IDLE → flush_o = 0.
- FSM, two states:
  - IDLE: winner present → next cycle state=PEND, redirect_valid=1, and redirect_target / redirect_src latch the winner's values. No winner → stay IDLE.
  - PEND: redirect_valid=1 and outputs held stable. If a new winner is present, reload target/src from it and stay PEND. This holds even if redirect_ready=1 in the same cycle: the new request is from an older instruction and supersedes the pending one. Else if redirect_ready=1 → IDLE, redirect_valid=0 next cycle. Else hold.
- Latency: request → flush in 0 cycles; request → redirect_valid in 1 cycle. Back-to-back redirects with ready constantly high give redirect_valid high for consecutive cycles.
- A stage-0 winner with kill_self=0 still produces a redirect with an empty flush mask (legal).

Optional Feature:
FLUSH_STATS_EN:
- Defined: flush_count increments by 1 on every cycle a winner exists (saturating at 32'hFFFFFFFF). stall_cycles increments on every cycle with state=PEND and redirect_ready=0 (saturating). Both reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter registers are instantiated.

Test Plan:
NUM_STAGES=5, NUM_SRC=3 for all scenarios.
- Single branch: src1 valid, stage=2, kill_self=0, target=32'h0040_0100, ready=1 → same cycle flush_o=5'b00011. Next cycle redirect_valid=1, target=32'h0040_0100, src=1. Following cycle redirect_valid=0.
- Priority by age: src0 (stage 1, target 32'h100) and src2 (stage 3, kill_self=1, target 32'h8000_0180) in the same cycle → flush_o=5'b01111, redirect_target=32'h8000_0180, src=2.
- Tie-break: src0 and src1 both at stage 2, targets 32'hA0 / 32'hB0 → target=32'hA0, src=0.
- Back-pressure: redirect issued, redirect_ready=0 for 3 cycles → redirect_valid and target stable, flush_o[0]=1 each cycle, stall_cycles=3 (FLUSH_STATS_EN). Ready=1 → IDLE next cycle.
- Supersede in PEND: pending target 32'h200, then src2 (stage 3, target 32'h300) arrives with ready=1 in the same cycle → stay PEND, target=32'h300, flush_o=5'b00111.
- Reset / invalid: rst_n deasserted low during PEND → redirect_valid=0 immediately, counters cleared. After release, src0 with stage=7 (out of range) → flush_o=0, no redirect.
